// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU fetch and data requests onto one
// single-ported RAM bus; data wins, stores lane-steered, loads
// right-justified and zero-filled, bus timeout reported as bus_err.
//
// Ports:
//   clk, rst           clock (rising), async active-high reset
//   imem_ren/addr      fetch request (level) and byte address
//   ihit, imem_load    fetch done pulse, fetched word (held)
//   dmem_ren/wen       load / store request (level, wen wins)
//   dmem_addr/width    data byte address, 00 b / 01 h / 1x w
//   dmem_store         right-justified store data
//   dhit, dmem_load    data done pulse, load data (held)
//   ram_req/wen/addr   bus request, write, word-aligned address
//   ram_be/wdata       byte enables, lane-replicated write data
//   ram_ready/rdata    bus completion pulse and read data
//   bus_err            pulses with a hit on timeout/misalignment
//
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned
// accesses without touching the bus.

module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ren,
  input  logic [31:0] imem_addr,
  output logic        ihit,
  output logic [31:0] imem_load,
  input  logic        dmem_ren,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_addr,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_store,
  output logic        dhit,
  output logic [31:0] dmem_load,
  output logic        ram_req,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_width;
  logic [1:0]  r_a;
  logic        r_wen;
  logic        r_ihit;
  logic        r_dhit;
  logic        r_err;
  logic [31:0] r_iload;
  logic [31:0] r_dload;
  logic        r_ram_req;
  logic        r_ram_wen;
  logic [31:0] r_ram_addr;
  logic [3:0]  r_ram_be;
  logic [31:0] r_ram_wdata;

  logic        w_dreq;
  logic [3:0]  w_sbe;
  logic [31:0] w_swdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;
  logic        w_isd;

  assign w_dreq = dmem_ren | dmem_wen;
  assign w_isd  = (r_state == DBUSY);

  // store lane steering from the live request (used at capture)
  always_comb begin
    w_sbe    = 4'b1111;
    w_swdata = dmem_store;
    unique case (dmem_width)
      2'b00: begin
        w_sbe    = 4'b0001 << dmem_addr[1:0];
        w_swdata = {4{dmem_store[7:0]}};
      end
      2'b01: begin
        w_sbe    = dmem_addr[1] ? 4'b1100 : 4'b0011;
        w_swdata = {2{dmem_store[15:0]}};
      end
      default: begin
        w_sbe    = 4'b1111;
        w_swdata = dmem_store;
      end
    endcase
  end

  // load extraction from the captured lane offset
  always_comb begin
    w_byte = ram_rdata[7:0];
    unique case (r_a)
      2'd0:    w_byte = ram_rdata[7:0];
      2'd1:    w_byte = ram_rdata[15:8];
      2'd2:    w_byte = ram_rdata[23:16];
      default: w_byte = ram_rdata[31:24];
    endcase
    w_half = r_a[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    unique case (r_width)
      2'b00:   w_ldata = {24'b0, w_byte};
      2'b01:   w_ldata = {16'b0, w_half};
      default: w_ldata = ram_rdata;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic w_dmis;
  logic w_imis;

  always_comb begin
    w_dmis = 1'b0;
    unique case (dmem_width)
      2'b00:   w_dmis = 1'b0;
      2'b01:   w_dmis = dmem_addr[0];
      default: w_dmis = |dmem_addr[1:0];
    endcase
  end

  assign w_imis = |imem_addr[1:0];
`else
  logic w_unused_ilow;
  assign w_unused_ilow = ^imem_addr[1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_width     <= 2'b00;
      r_a         <= 2'b00;
      r_wen       <= 1'b0;
      r_ihit      <= 1'b0;
      r_dhit      <= 1'b0;
      r_err       <= 1'b0;
      r_iload     <= 32'd0;
      r_dload     <= 32'd0;
      r_ram_req   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= 32'd0;
      r_ram_be    <= 4'b0000;
      r_ram_wdata <= 32'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ihit <= 1'b0;
          r_dhit <= 1'b0;
          r_err  <= 1'b0;
          r_cnt  <= 8'd0;
          if (w_dreq) begin
            r_wen   <= dmem_wen;
            r_width <= dmem_width;
            r_a     <= dmem_addr[1:0];
`ifdef MEM_ALIGN_CHECK_EN
            if (w_dmis) begin
              r_state <= RESP;
              r_dhit  <= 1'b1;
              r_err   <= 1'b1;
              if (!dmem_wen)
                r_dload <= 32'd0;
            end else begin
`else
            begin
`endif
              r_state     <= DBUSY;
              r_ram_req   <= 1'b1;
              r_ram_wen   <= dmem_wen;
              r_ram_addr  <= {dmem_addr[31:2], 2'b00};
              r_ram_be    <= dmem_wen ? w_sbe : 4'b1111;
              r_ram_wdata <= w_swdata;
            end
          end else if (imem_ren) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (w_imis) begin
              r_state <= RESP;
              r_ihit  <= 1'b1;
              r_err   <= 1'b1;
              r_iload <= 32'd0;
            end else begin
`else
            begin
`endif
              r_state    <= IBUSY;
              r_ram_req  <= 1'b1;
              r_ram_wen  <= 1'b0;
              r_ram_addr <= {imem_addr[31:2], 2'b00};
              r_ram_be   <= 4'b1111;
            end
          end
        end
        DBUSY, IBUSY: begin
          r_cnt <= r_cnt + 8'd1;
          // a ready arriving on the last allowed cycle still wins
          if (ram_ready) begin
            r_state   <= RESP;
            r_ram_req <= 1'b0;
            r_ram_wen <= 1'b0;
            if (w_isd) begin
              r_dhit <= 1'b1;
              if (!r_wen)
                r_dload <= w_ldata;
            end else begin
              r_ihit  <= 1'b1;
              r_iload <= ram_rdata;
            end
          end else if (r_cnt == TO_LAST) begin
            r_state   <= RESP;
            r_ram_req <= 1'b0;
            r_ram_wen <= 1'b0;
            r_err     <= 1'b1;
            if (w_isd) begin
              r_dhit <= 1'b1;
              if (!r_wen)
                r_dload <= 32'd0;
            end else begin
              r_ihit  <= 1'b1;
              r_iload <= 32'd0;
            end
          end
        end
        RESP: begin
          // one dead cycle lets the datapath drop its request
          r_ihit  <= 1'b0;
          r_dhit  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ihit      = r_ihit;
  assign dhit      = r_dhit;
  assign bus_err   = r_err;
  assign imem_load = r_iload;
  assign dmem_load = r_dload;
  assign ram_req   = r_ram_req;
  assign ram_wen   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_be    = r_ram_be;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        ihit;
  logic [31:0] imem_load;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_store;
  logic        dhit;
  logic [31:0] dmem_load;
  logic        ram_req;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_ready;
  logic [31:0] ram_rdata;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .ihit(ihit), .imem_load(imem_load),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_width(dmem_width),
    .dmem_store(dmem_store),
    .dhit(dhit), .dmem_load(dmem_load),
    .ram_req(ram_req), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_ren = 0; imem_addr = 0;
    dmem_ren = 0; dmem_wen = 0;
    dmem_addr = 0; dmem_width = 0; dmem_store = 0;
    ram_ready = 0; ram_rdata = 0;
    #12;
    chk("rst_req", {31'd0, ram_req}, 0);
    chk("rst_hits", {29'd0, ihit, dhit, bus_err}, 0);
    chk("rst_be", {28'd0, ram_be}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dload", dmem_load, 0);
    rst = 1'b0;
    step();

    // fetch 0x100, ready 3 cycles after req
    imem_ren = 1; imem_addr = 32'h100;
    step();
    imem_ren = 0;
    chk("f_req", {31'd0, ram_req}, 1);
    chk("f_addr", ram_addr, 32'h100);
    chk("f_be", {28'd0, ram_be}, 4'hF);
    chk("f_wen", {31'd0, ram_wen}, 0);
    step();
    step();
    chk("f_wait", {30'd0, ram_req, ihit}, 2'b10);
    ram_ready = 1; ram_rdata = 32'h00500093;
    step();
    ram_ready = 0;
    chk("f_ihit", {31'd0, ihit}, 1);
    chk("f_iload", imem_load, 32'h00500093);
    chk("f_req_off", {31'd0, ram_req}, 0);
    step();
    chk("f_ihit_pulse", {31'd0, ihit}, 0);

    // simultaneous fetch + data: data first
    imem_ren = 1; imem_addr = 32'h300;
    dmem_ren = 1; dmem_addr = 32'h204;
    dmem_width = 2'b10;
    step();
    dmem_ren = 0;
    chk("p_addr", ram_addr, 32'h204);
    chk("p_wen", {31'd0, ram_wen}, 0);
    ram_ready = 1; ram_rdata = 32'h11223344;
    step();
    ram_ready = 0;
    chk("p_hits", {30'd0, ihit, dhit}, 2'b01);
    chk("p_dload", dmem_load, 32'h11223344);
    step();
    chk("p_resp_ign", {31'd0, ram_req}, 0);
    step();
    imem_ren = 0;
    chk("p_faddr", ram_addr, 32'h300);
    chk("p_freq", {31'd0, ram_req}, 1);
    ram_ready = 1; ram_rdata = 32'hDEADBEEF;
    step();
    ram_ready = 0;
    chk("p_ihit", {30'd0, ihit, dhit}, 2'b10);
    chk("p_iload", imem_load, 32'hDEADBEEF);
    step();

    // byte store 0xAB to 0x203
    dmem_wen = 1; dmem_addr = 32'h203;
    dmem_width = 2'b00; dmem_store = 32'h000000AB;
    step();
    dmem_wen = 0;
    chk("sb_be", {28'd0, ram_be}, 4'b1000);
    chk("sb_wdata", ram_wdata, 32'hABABABAB);
    chk("sb_wen", {31'd0, ram_wen}, 1);
    chk("sb_addr", ram_addr, 32'h200);
    ram_ready = 1; ram_rdata = 32'h55555555;
    step();
    ram_ready = 0;
    chk("sb_dhit", {31'd0, dhit}, 1);
    chk("sb_dload", dmem_load, 32'h11223344);
    step();

    // half store 0x5678 to 0x100, load+store both high
    dmem_ren = 1; dmem_wen = 1;
    dmem_addr = 32'h100; dmem_width = 2'b01;
    dmem_store = 32'h99995678;
    step();
    dmem_ren = 0; dmem_wen = 0;
    chk("sh_be", {28'd0, ram_be}, 4'b0011);
    chk("sh_wdata", ram_wdata, 32'h56785678);
    chk("sh_wen", {31'd0, ram_wen}, 1);
    ram_ready = 1;
    step();
    ram_ready = 0;
    step();

    // width 11 store acts as word
    dmem_wen = 1; dmem_addr = 32'h10;
    dmem_width = 2'b11; dmem_store = 32'h12345678;
    step();
    dmem_wen = 0;
    chk("sw_be", {28'd0, ram_be}, 4'hF);
    chk("sw_wdata", ram_wdata, 32'h12345678);
    ram_ready = 1;
    step();
    ram_ready = 0;
    step();

    // half load from 0x102
    dmem_ren = 1; dmem_addr = 32'h102;
    dmem_width = 2'b01;
    step();
    dmem_ren = 0;
    chk("lh_addr", ram_addr, 32'h100);
    chk("lh_be", {28'd0, ram_be}, 4'hF);
    ram_ready = 1; ram_rdata = 32'hBEEF1234;
    step();
    ram_ready = 0;
    chk("lh_dload", dmem_load, 32'h0000BEEF);
    step();

    // byte load from 0x101
    dmem_ren = 1; dmem_addr = 32'h101;
    dmem_width = 2'b00;
    step();
    dmem_ren = 0;
    ram_ready = 1; ram_rdata = 32'hBEEF1234;
    step();
    ram_ready = 0;
    chk("lb_dload", dmem_load, 32'h00000012);
    step();

    // timeout after 4 cycles
    dmem_ren = 1; dmem_addr = 32'h40;
    dmem_width = 2'b10;
    step();
    dmem_ren = 0;
    chk("to_req0", {31'd0, ram_req}, 1);
    step();
    step();
    step();
    chk("to_req3", {30'd0, ram_req, dhit}, 2'b10);
    step();
    chk("to_req_off", {31'd0, ram_req}, 0);
    chk("to_hit_err", {30'd0, dhit, bus_err}, 2'b11);
    chk("to_dload", dmem_load, 0);
    step();
    chk("to_pulse", {30'd0, dhit, bus_err}, 2'b00);

    // stray ram_ready in IDLE is ignored
    ram_ready = 1; ram_rdata = 32'hFFFFFFFF;
    step();
    step();
    ram_ready = 0;
    chk("idle_rdy", {29'd0, ihit, dhit, ram_req}, 0);
    chk("idle_dload", dmem_load, 0);

    // misaligned word load at 0x101
    dmem_ren = 1; dmem_addr = 32'h101;
    dmem_width = 2'b10;
    step();
    dmem_ren = 0;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_req", {31'd0, ram_req}, 0);
    chk("mis_hit_err", {30'd0, dhit, bus_err}, 2'b11);
    chk("mis_dload", dmem_load, 0);
    step();
`else
    chk("mis_addr", ram_addr, 32'h100);
    chk("mis_req", {31'd0, ram_req}, 1);
    ram_ready = 1; ram_rdata = 32'hCAFEF00D;
    step();
    ram_ready = 0;
    chk("mis_hit_err", {30'd0, dhit, bus_err}, 2'b10);
    chk("mis_dload", dmem_load, 32'hCAFEF00D);
    step();
`endif
    step();

    // async reset mid-fetch
    imem_ren = 1; imem_addr = 32'h400;
    step();
    imem_ren = 0;
    chk("ar_req", {31'd0, ram_req}, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_async", {31'd0, ram_req}, 0);
    ram_ready = 1;
    step();
    ram_ready = 0;
    rst = 1'b0;
    step();
    chk("ar_nohit", {29'd0, ihit, dhit, ram_req}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
